// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding used by the arbiter, the ALU and the bench.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_t;

  localparam int ALU_W = 4;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Two-requester operation bus plus single response channel of the shared ALU.
interface alu_rr_arbiter_if;
  import alu_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [ALU_W-1:0] req0_a;
  logic [ALU_W-1:0] req0_b;
  logic [2:0]       req0_sel;

  logic             req1_valid;
  logic             req1_ready;
  logic [ALU_W-1:0] req1_a;
  logic [ALU_W-1:0] req1_b;
  logic [2:0]       req1_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [ALU_W-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf
  );

endinterface

// File: rtl/alu_rr_arbiter_alu_4bit.sv
// Purely combinational 4-bit ALU with Zero/Carry/Overflow flags.
module alu_4bit
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  alu_op_t    ALU_Sel,
  output logic [3:0] ALU_Result,
  output logic       Zero,
  output logic       Carry,
  output logic       Overflow
);

  logic [4:0] sum;
  logic [4:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Carry of SUB is the borrow, which is bit 4 of the zero-extended difference
  always_comb begin
    ALU_Result = 4'b0000;
    Carry      = 1'b0;
    Overflow   = 1'b0;
    case (ALU_Sel)
      ALU_ADD: begin
        ALU_Result = sum[3:0];
        Carry      = sum[4];
        Overflow   = (a[3] == b[3]) && (sum[3] != a[3]);
      end
      ALU_SUB: begin
        ALU_Result = diff[3:0];
        Carry      = diff[4];
        Overflow   = (a[3] != b[3]) && (diff[3] != a[3]);
      end
      ALU_AND: ALU_Result = a & b;
      ALU_OR:  ALU_Result = a | b;
      ALU_XOR: ALU_Result = a ^ b;
      ALU_NOT: ALU_Result = ~a;
      ALU_SHL: begin
        ALU_Result = {a[2:0], 1'b0};
        Carry      = a[3];
      end
      ALU_SHR: begin
        ALU_Result = {1'b0, a[3:1]};
        Carry      = a[0];
      end
      default: ALU_Result = 4'b0000;
    endcase
  end

  assign Zero = (ALU_Result == 4'b0000);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one 4-bit ALU between two requesters, with a single
// registered response slot and saturating per-requester acceptance counters.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int FIRST_GRANT = 0,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_rr_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
);

  localparam logic PRIO_RST = (FIRST_GRANT != 0);

  // prio names the requester that wins the next contended cycle
  logic       prio;
  logic       grant0;
  logic       grant1;
  logic       out_free;
  logic       accept0;
  logic       accept1;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  alu_op_t    alu_sel;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_ovf;

  assign grant0   = bus.req0_valid && (!bus.req1_valid || !prio);
  assign grant1   = bus.req1_valid && (!bus.req0_valid ||  prio);
  assign out_free = !bus.rsp_valid || bus.rsp_ready;
  assign accept0  = grant0 && out_free;
  assign accept1  = grant1 && out_free;

  // Reset gates only the outputs so that rst_n never reaches a flop data input
  assign bus.req0_ready = accept0 && rst_n;
  assign bus.req1_ready = accept1 && rst_n;

  assign alu_a   = grant1 ? bus.req1_a : bus.req0_a;
  assign alu_b   = grant1 ? bus.req1_b : bus.req0_b;
  assign alu_sel = alu_op_t'(grant1 ? bus.req1_sel : bus.req0_sel);

  alu_4bit u_alu (
    .a          (alu_a),
    .b          (alu_b),
    .ALU_Sel    (alu_sel),
    .ALU_Result (alu_result),
    .Zero       (alu_zero),
    .Carry      (alu_carry),
    .Overflow   (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio           <= PRIO_RST;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= 4'b0000;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_ovf    <= 1'b0;
    end else if (accept0 || accept1) begin
      prio           <= accept0;
      bus.rsp_valid  <= 1'b1;
      bus.rsp_id     <= accept1;
      bus.rsp_result <= alu_result;
      bus.rsp_zero   <= alu_zero;
      bus.rsp_carry  <= alu_carry;
      bus.rsp_ovf    <= alu_ovf;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (accept0 && !(&cnt0)) cnt0 <= cnt0 + 1'b1;
      if (accept1 && !(&cnt1)) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed scoreboard bench for alu_rr_arbiter, plus a CNT_W=2 instance for saturation.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic       id;
    logic [3:0] res;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] sat_cnt0;
  logic [1:0] sat_cnt1;

  int vectors;
  int miscompares;
  exp_t exp_q[$];
  logic prio_m;
  int cnt0_m;
  int cnt1_m;

  alu_rr_arbiter_if ifc ();
  alu_rr_arbiter_if ifc2 ();

  alu_rr_arbiter #(.FIRST_GRANT(0), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave),
    .cnt0  (cnt0),
    .cnt1  (cnt1)
  );

  alu_rr_arbiter #(.FIRST_GRANT(0), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc2.slave),
    .cnt0  (sat_cnt0),
    .cnt1  (sat_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t alu_model(input logic id, input logic [3:0] a, input logic [3:0] b,
                                     input logic [2:0] sel);
    exp_t e;
    int ua, ub, sa, sb, r, s;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    e.id = id;
    e.c = 1'b0;
    e.v = 1'b0;
    case (sel)
      3'd0: begin r = ua + ub; e.c = (r > 15); s = sa + sb; e.v = (s > 7) || (s < -8); end
      3'd1: begin r = ua - ub; e.c = (ua < ub); s = sa - sb; e.v = (s > 7) || (s < -8); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 15 - ua;
      3'd6: begin r = ua * 2; e.c = (ua > 7); end
      default: begin r = ua / 2; e.c = ((ua % 2) == 1); end
    endcase
    r = r & 15;
    e.res = r[3:0];
    e.z = (r == 0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; drives one cycle of stimulus and returns at the next falling edge
  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic [2:0] s0, input logic v1, input logic [3:0] a1,
                               input logic [3:0] b1, input logic [2:0] s1, input logic rr);
    logic free_m, r0_m, r1_m;
    ifc.req0_valid = v0; ifc.req0_a = a0; ifc.req0_b = b0; ifc.req0_sel = s0;
    ifc.req1_valid = v1; ifc.req1_a = a1; ifc.req1_b = b1; ifc.req1_sel = s1;
    ifc.rsp_ready  = rr;
    #1;
    free_m = (exp_q.size() == 0) || rr;
    r0_m = v0 && (!v1 || !prio_m) && free_m;
    r1_m = v1 && (!v0 ||  prio_m) && free_m;
    checkOutput("req0_ready", {7'd0, ifc.req0_ready}, {7'd0, r0_m});
    checkOutput("req1_ready", {7'd0, ifc.req1_ready}, {7'd0, r1_m});
    checkOutput("cnt0", cnt0, 8'(cnt0_m));
    checkOutput("cnt1", cnt1, 8'(cnt1_m));
    if (exp_q.size() > 0) begin
      checkOutput("rsp_valid", {7'd0, ifc.rsp_valid}, 8'd1);
      checkOutput("rsp_id", {7'd0, ifc.rsp_id}, {7'd0, exp_q[0].id});
      checkOutput("rsp_result", {4'd0, ifc.rsp_result}, {4'd0, exp_q[0].res});
      checkOutput("rsp_flags", {5'd0, ifc.rsp_zero, ifc.rsp_carry, ifc.rsp_ovf},
                  {5'd0, exp_q[0].z, exp_q[0].c, exp_q[0].v});
    end else begin
      checkOutput("rsp_valid", {7'd0, ifc.rsp_valid}, 8'd0);
    end
    @(posedge clk);
    if (exp_q.size() > 0 && rr) void'(exp_q.pop_front());
    if (r0_m) begin
      exp_q.push_back(alu_model(1'b0, a0, b0, s0));
      prio_m = 1'b1;
      if (cnt0_m < 255) cnt0_m++;
    end
    if (r1_m) begin
      exp_q.push_back(alu_model(1'b1, a1, b1, s1));
      prio_m = 1'b0;
      if (cnt1_m < 255) cnt1_m++;
    end
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic rr);
    applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 4'd0, 4'd0, 3'd0, rr);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    prio_m = 1'b0;
    cnt0_m = 0;
    cnt1_m = 0;
    rst_n = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_a = 4'd0; ifc.req0_b = 4'd0; ifc.req0_sel = 3'd0;
    ifc.req1_valid = 1'b1; ifc.req1_a = 4'd0; ifc.req1_b = 4'd0; ifc.req1_sel = 3'd0;
    ifc.rsp_ready  = 1'b1;
    ifc2.req0_valid = 1'b0; ifc2.req0_a = 4'd0; ifc2.req0_b = 4'd0; ifc2.req0_sel = 3'd0;
    ifc2.req1_valid = 1'b0; ifc2.req1_a = 4'd3; ifc2.req1_b = 4'd1; ifc2.req1_sel = 3'd0;
    ifc2.rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {6'd0, ifc.req0_ready, ifc.req1_ready}, 8'd0);
    checkOutput("reset_rsp", {1'd0, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_zero, ifc.rsp_carry,
                ifc.rsp_ovf, 2'd0}, 8'd0);
    checkOutput("reset_result", {4'd0, ifc.rsp_result}, 8'd0);
    checkOutput("reset_cnt", cnt0 | cnt1, 8'd0);
    rst_n = 1'b1;

    $display("[TB] contention: alternating grants");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 4'(i), 4'd1, 3'd0, 1'b1, 4'(i + 8), 4'd2, 3'd1, 1'b1);
    idleCycle(1'b1);
    checkOutput("cnt0_after_rr", cnt0, 8'd2);
    checkOutput("cnt1_after_rr", cnt1, 8'd2);

    $display("[TB] single requester ADD");
    applyStimulus(1'b1, 4'b0010, 4'b0101, 3'b000, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    checkOutput("add_result", {4'd0, ifc.rsp_result}, 8'b0111);
    idleCycle(1'b1);
    idleCycle(1'b1);

    $display("[TB] flag vectors");
    applyStimulus(1'b1, 4'b0111, 4'b0001, 3'b000, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b0000, 4'b0001, 3'b001, 1'b1);
    applyStimulus(1'b1, 4'b1101, 4'b0000, 3'b111, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b0101, 4'b0101, 3'b100, 1'b1);
    applyStimulus(1'b1, 4'b1001, 4'b0000, 3'b110, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    applyStimulus(1'b1, 4'b0101, 4'b0000, 3'b101, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b1100, 4'b1010, 3'b010, 1'b1);
    applyStimulus(1'b1, 4'b1100, 4'b0011, 3'b011, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    applyStimulus(1'b1, 4'b1000, 4'b1000, 3'b000, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    applyStimulus(1'b1, 4'b1000, 4'b0001, 3'b001, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 4'b0011, 4'b0100, 3'b000, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 4'b1111, 4'b1111, 3'b010, 1'b1, 4'b0110, 4'b0011, 3'b001, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 3'b010, 1'b1, 4'b0110, 4'b0011, 3'b001, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);

    $display("[TB] reset with response held");
    applyStimulus(1'b1, 4'b0001, 4'b0001, 3'b000, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    checkOutput("held_before_reset", {7'd0, ifc.rsp_valid}, 8'd1);
    #2;
    rst_n = 1'b0;
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    ifc.rsp_ready  = 1'b1;
    #1;
    checkOutput("async_reset_rsp", {1'd0, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_zero, ifc.rsp_carry,
                ifc.rsp_ovf, ifc.req0_ready, ifc.req1_ready}, 8'd0);
    checkOutput("async_reset_result", {4'd0, ifc.rsp_result}, 8'd0);
    checkOutput("async_reset_cnt", cnt0 | cnt1, 8'd0);
    exp_q.delete();
    prio_m = 1'b0;
    cnt0_m = 0;
    cnt1_m = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0110, 4'b0001, 3'b000, 1'b1, 4'b0001, 4'b0001, 3'b000, 1'b1);
    checkOutput("first_grant_id", {7'd0, ifc.rsp_id}, 8'd0);
    idleCycle(1'b1);
    idleCycle(1'b1);

    $display("[TB] counter saturation at CNT_W=2");
    ifc2.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("sat_cnt1", {6'd0, sat_cnt1}, (i < 3) ? 8'(i + 1) : 8'd3);
    end
    ifc2.req1_valid = 1'b0;
    checkOutput("sat_cnt0", {6'd0, sat_cnt0}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
REQ-001 Parameter: FIRST_GRANT, default 0, the requester that wins the first contended cycle after reset (0 or 1).
REQ-002 Parameter: CNT_W, default 8, width of the per-requester accepted-operation counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready / req1_ready  output  1  operation accepted this cycle when valid && ready.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  4  operands of requester N.
REQ-008 req0_sel / req1_sel  input  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHL a, 111 SHR a.
REQ-009 rsp_valid  output  1  a result is held in the output register.
REQ-010 rsp_ready  input  1  consumer takes the result when rsp_valid && rsp_ready.
REQ-011 rsp_id  output  1  requester that issued the held result.
REQ-012 rsp_result  output  4  ALU_Result of the held operation.
REQ-013 rsp_zero, rsp_carry, rsp_ovf  output  1 each  Zero, Carry, Overflow flags of the held operation.
REQ-014 cnt0 / cnt1  output  CNT_W  operations accepted from requester N, saturating.

Function
REQ-015 The block SHALL share one combinational 4-bit ALU between two requesters and return results over one response channel.
REQ-016 Output register SHALL be "free" when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1 in the same cycle (drain and refill together).
REQ-017 Grant: only one valid -> that requester; both valid -> the requester not granted at the last acceptance (after reset, FIRST_GRANT); none -> no grant.
REQ-018 reqN_ready SHALL be grant_N AND output-register-free; ready of the non-granted requester SHALL be 0.
REQ-019 The round-robin pointer SHALL update only on an actual acceptance, never on a grant without acceptance.
REQ-020 On acceptance, the ALU result, flags and requester id SHALL load into the output register; rsp_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-021 Held response SHALL remain stable until handshaken; with rsp_ready held at 1, one operation SHALL complete per cycle.
REQ-022 When the output register drains without a new acceptance, rsp_valid SHALL drop to 0 on the next cycle.
REQ-023 ALU arithmetic: ADD carry = bit 4 of a+b; SUB carry = borrow (a<b); overflow = signed 4-bit overflow for ADD/SUB, 0 otherwise.
REQ-024 SHL/SHR: shift by 1, zero-fill, carry = shifted-out bit.
REQ-025 For logic ops and NOT, carry SHALL be 0. Zero SHALL be set when the result is 4'b0000.
REQ-026 cntN SHALL increment by 1 on each acceptance from requester N and hold at all-ones.
REQ-027 Requester inputs SHALL NOT need to remain stable after acceptance; operands are consumed in the accepting cycle.

Reset
REQ-028 While rst_n=0: rsp_valid=0, rsp_id=0, rsp_result=0, all flags 0, cnt0=cnt1=0, RR pointer=FIRST_GRANT, req0_ready=req1_ready=0.
REQ-029 Reset asserted mid-transaction SHALL discard the held response with no completion reported; the first acceptance SHALL occur in the first rising edge after rst_n rises.

Structure
REQ-030 Shared package alu_pkg SHALL hold opcode constants (ALU_ADD..ALU_SHR) and the 3-bit opcode typedef.
REQ-031 The ALU SHALL be one sub-module, alu_4bit (ports a, b, ALU_Sel, ALU_Result, Zero, Carry, Overflow), instantiated once.
REQ-032 Arbitration, output register and counters SHALL be in alu_rr_arbiter itself.

Verification
REQ-033 req0 alone: a=0010, b=0101, sel=000, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=0111, Z=0, C=0, V=0; cnt0=1.
REQ-034 Both valid for 4 cycles, rsp_ready=1, FIRST_GRANT=0 -> ids 0,1,0,1 on consecutive cycles; cnt0=cnt1=2.
REQ-035 Backpressure: hold rsp_ready=0 with a response held -> both req*_ready=0 and the response is stable; raise rsp_ready -> drain and new accept in the same cycle.
REQ-036 Flags: ADD 0111+0001 -> 1000, V=1, C=0. SUB 0000-0001 -> 1111, C=1. SHR 1101 -> 0110, C=1. XOR 0101^0101 -> 0000, Z=1.
REQ-037 Reset asserted with rsp_valid=1 -> all outputs 0 asynchronously; after release, both valid -> FIRST_GRANT wins.
REQ-038 CNT_W=2, 5 accepts from req1 -> cnt1 saturates at 11.
